// File: rtl/multiply_divide_unit_pkg.sv
// Shared op codes, FSM encodings and arithmetic helpers for the multi-cycle
// multiply/divide unit in the EX stage.
package multiply_divide_unit_pkg;

  localparam logic [3:0] mduOfNone  = 4'b0000;
  localparam logic [3:0] mduOfMult  = 4'b0001;
  localparam logic [3:0] mduOfMultu = 4'b0010;
  localparam logic [3:0] mduOfDiv   = 4'b0011;
  localparam logic [3:0] mduOfDivu  = 4'b0100;
  localparam logic [3:0] mduOfMfhi  = 4'b0101;
  localparam logic [3:0] mduOfMflo  = 4'b0110;
  localparam logic [3:0] mduOfMthi  = 4'b0111;
  localparam logic [3:0] mduOfMtlo  = 4'b1000;

  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which the
  // unsigned divider then treats as 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/multiply_divide_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with private HI/LO; results are computed at
// issue and held in pending registers until the latency counter expires.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 32'd5,
  parameter int unsigned DIV_LATENCY  = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mduInputA,
  input  logic [31:0] mduInputB,
  input  logic [3:0]  mduOperation,
  input  logic        mduStart,
  output logic        mduBusy,
  output logic [31:0] mduOutput
);

  localparam int unsigned MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int unsigned CW      = $clog2(MAX_LAT + 32'd1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          r_busy;

  logic [63:0] w_prod_s, w_prod_u, w_next_pend;
  logic [31:0] w_a_mag, w_b_mag, w_den_s, w_den_u;
  logic [31:0] w_uq, w_ur, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic        w_b_zero;

  assign w_prod_s = $signed({{32{mduInputA[31]}}, mduInputA}) * $signed({{32{mduInputB[31]}}, mduInputB});
  assign w_prod_u = {32'd0, mduInputA} * {32'd0, mduInputB};

  // Signed divide goes through magnitudes so the MIN/-1 case never overflows.
  assign w_b_zero = (mduInputB == 32'd0);
  assign w_a_mag  = mag32(mduInputA);
  assign w_b_mag  = mag32(mduInputB);
  assign w_den_s  = w_b_zero ? 32'd1 : w_b_mag;
  assign w_den_u  = w_b_zero ? 32'd1 : mduInputB;
  assign w_uq     = w_a_mag / w_den_s;
  assign w_ur     = w_a_mag % w_den_s;
  assign w_quo_s  = (mduInputA[31] ^ mduInputB[31]) ? (32'd0 - w_uq) : w_uq;
  assign w_rem_s  = mduInputA[31] ? (32'd0 - w_ur) : w_ur;
  assign w_quo_u  = mduInputA / w_den_u;
  assign w_rem_u  = mduInputA % w_den_u;

  // Pending {HI,LO}; divide by zero leaves the current pair in place.
  always_comb begin
    w_next_pend = {r_hi, r_lo};
    case (mduOperation)
      mduOfMult:  w_next_pend = w_prod_s;
      mduOfMultu: w_next_pend = w_prod_u;
      mduOfDiv:   w_next_pend = w_b_zero ? {r_hi, r_lo} : {w_rem_s, w_quo_s};
      mduOfDivu:  w_next_pend = w_b_zero ? {r_hi, r_lo} : {w_rem_u, w_quo_u};
      default:    w_next_pend = {r_hi, r_lo};
    endcase
  end

  // FSM, latency counter, HI/LO and pending registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MDU_IDLE;
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (mduStart) begin
            case (mduOperation)
              mduOfMult, mduOfMultu: begin
                {r_pend_hi, r_pend_lo} <= w_next_pend;
                r_count <= CW'(MULT_LATENCY);
                r_state <= MDU_RUN;
                r_busy  <= 1'b1;
              end
              mduOfDiv, mduOfDivu: begin
                {r_pend_hi, r_pend_lo} <= w_next_pend;
                r_count <= CW'(DIV_LATENCY);
                r_state <= MDU_RUN;
                r_busy  <= 1'b1;
              end
              mduOfMthi: r_hi <= mduInputA;
              mduOfMtlo: r_lo <= mduInputA;
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= MDU_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= MDU_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mduBusy = r_busy;

  // Move-from path is combinational on the op code.
  always_comb begin
    case (mduOperation)
      mduOfMfhi: mduOutput = r_hi;
      mduOfMflo: mduOutput = r_lo;
      default:   mduOutput = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard bench for multiply_divide_unit: stimulus queues expected MF reads
// and busy-run lengths, a negedge monitor pops and compares them.
module tb_multiply_divide_unit;
  import multiply_divide_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mduInputA = 32'd0;
  logic [31:0] mduInputB = 32'd0;
  logic [3:0]  mduOperation = 4'b0000;
  logic        mduStart = 1'b0;
  logic        mduBusy;
  logic [31:0] mduOutput;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   busy_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   run_len = 0;

  multiply_divide_unit #(.MULT_LATENCY(5), .DIV_LATENCY(10)) dut (
    .clk(clk), .reset(reset), .mduInputA(mduInputA), .mduInputB(mduInputB),
    .mduOperation(mduOperation), .mduStart(mduStart), .mduBusy(mduBusy), .mduOutput(mduOutput)
  );

  always #5 clk = ~clk;

  // Monitor: compares MF reads and completed busy runs against the queues.
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else begin
      if (mduBusy) begin
        run_len++;
      end else if (run_len != 0) begin
        n_vec++;
        if (busy_q.size() == 0) begin
          n_miss++;
          $display("FAIL busy_run: got %0d cycles, required none queued", run_len);
        end else begin
          int e;
          e = busy_q.pop_front();
          if (run_len != e) begin
            n_miss++;
            $display("FAIL busy_run: got %0d cycles, required %0d", run_len, e);
          end
        end
        run_len = 0;
      end
      if (mduOperation == mduOfMfhi || mduOperation == mduOfMflo) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_read: got %h, nothing queued", mduOutput);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (mduOutput !== e.val) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", e.name, mduOutput, e.val);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    mduOperation = op;
    mduInputA = a;
    mduInputB = b;
    mduStart = 1'b1;
    if (lat > 0) busy_q.push_back(lat);
    cycle();
    mduStart = 1'b0;
    mduOperation = mduOfNone;
  endtask

  task automatic read(input logic [3:0] op, input logic [31:0] val, input string name);
    exp_t e;
    e.name = name;
    e.val = val;
    exp_q.push_back(e);
    mduOperation = op;
    cycle();
    mduOperation = mduOfNone;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && mduBusy; i++) cycle();
    check("wait_idle_timeout", {31'd0, mduBusy}, 32'd0);
  endtask

  initial begin
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("reset_busy", {31'd0, mduBusy}, 32'd0);
    read(mduOfMfhi, 32'h0, "reset_hi");
    read(mduOfMflo, 32'h0, "reset_lo");

    // Reset in the middle of a MULT discards it.
    issue(mduOfMult, 32'd7, 32'd6, 0);
    cycle();
    cycle();
    #2 reset = 1'b1;
    #1 check("midrun_reset_busy", {31'd0, mduBusy}, 32'd0);
    #3 reset = 1'b0;
    cycle();
    read(mduOfMflo, 32'h0, "midrun_reset_lo");
    read(mduOfMfhi, 32'h0, "midrun_reset_hi");

    issue(mduOfMult, 32'hFFFFFFFF, 32'd2, 5);
    wait_idle();
    read(mduOfMfhi, 32'hFFFFFFFF, "mult_hi");
    read(mduOfMflo, 32'hFFFFFFFE, "mult_lo");

    issue(mduOfMultu, 32'hFFFFFFFF, 32'd2, 5);
    wait_idle();
    read(mduOfMfhi, 32'h00000001, "multu_hi");
    read(mduOfMflo, 32'hFFFFFFFE, "multu_lo");

    issue(mduOfDiv, 32'hFFFFFFF9, 32'd2, 10);
    wait_idle();
    read(mduOfMflo, 32'hFFFFFFFD, "div_neg_lo");
    read(mduOfMfhi, 32'hFFFFFFFF, "div_neg_hi");

    issue(mduOfDivu, 32'd7, 32'd2, 10);
    wait_idle();
    read(mduOfMflo, 32'd3, "divu_lo");
    read(mduOfMfhi, 32'd1, "divu_hi");

    issue(mduOfDiv, 32'h80000000, 32'hFFFFFFFF, 10);
    wait_idle();
    read(mduOfMflo, 32'h80000000, "div_ovf_lo");
    read(mduOfMfhi, 32'h0, "div_ovf_hi");

    issue(mduOfMthi, 32'h11, 32'd0, 0);
    read(mduOfMfhi, 32'h11, "mthi");
    issue(mduOfMtlo, 32'h22, 32'd0, 0);
    read(mduOfMflo, 32'h22, "mtlo");
    issue(mduOfDivu, 32'd5, 32'd0, 10);
    wait_idle();
    read(mduOfMfhi, 32'h11, "divz_hi");
    read(mduOfMflo, 32'h22, "divz_lo");

    // MTLO during a DIV run is dropped; MF sees pre-op LO until commit.
    issue(mduOfDiv, 32'd100, 32'd7, 10);
    issue(mduOfMtlo, 32'hAA, 32'd0, 0);
    read(mduOfMflo, 32'h22, "mf_during_run");
    mduOperation = mduOfMult;
    #1 check("non_mf_output", mduOutput, 32'h0);
    mduOperation = mduOfNone;
    wait_idle();
    read(mduOfMflo, 32'd14, "mtlo_ignored_lo");
    read(mduOfMfhi, 32'd2, "mtlo_ignored_hi");

    // Back-to-back: second MULT lands on the first non-busy cycle.
    issue(mduOfMultu, 32'h00010000, 32'h00030000, 5);
    wait_idle();
    issue(mduOfMult, 32'hFFFFFFFF, 32'd5, 5);
    check("b2b_accepted", {31'd0, mduBusy}, 32'd1);
    read(mduOfMfhi, 32'd3, "b2b_old_hi");
    wait_idle();
    read(mduOfMfhi, 32'hFFFFFFFF, "b2b_hi");
    read(mduOfMflo, 32'hFFFFFFFB, "b2b_lo");

    cycle();
    cycle();
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("busy_q_drained", busy_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS datapath, beside the single-cycle ALU. It accepts the same two 32-bit register operands. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles into private HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. The hazard unit stalls on `mduBusy` (or on a strobed mult/div in the same cycle).

## Interface
- `MULT_LATENCY`, default 5: busy cycles for MULT/MULTU (>=1).
- `DIV_LATENCY`, default 10: busy cycles for DIV/DIVU (>=1).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `mduInputA`  in  32  — rs operand.
- `mduInputB`  in  32  — rt operand.
- `mduOperation`  in  4  — op code from the shared package.
- `mduStart`  in  1  — issue strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- `mduBusy`  out  1  — registered; high while an operation is in flight.
- `mduOutput`  out  32  — combinational: HI for MFHI, LO for MFLO, else 0.

## Operation
- State machine: IDLE, RUN. Down-counter `count`, pending registers `pendHi`/`pendLo`.
- IDLE with `mduStart`=1:
  - MULT/MULTU/DIV/DIVU: latch results into `pendHi`/`pendLo`, load `count` with the op's latency, go to RUN.
  - MTHI: HI←A at this edge; stay IDLE. MTLO: LO←A at this edge; stay IDLE.
  - MFHI/MFLO/none with strobe: no state change.
- RUN: decrement `count` each edge. At the edge where `count`==1, commit HI←`pendHi`, LO←`pendLo` and go to IDLE.
- `mduBusy` = (state==RUN).
- `mduStart` in RUN: ignored entirely, including MTHI/MTLO.
- MULT: {HI,LO} = signed A × signed B, full 64-bit. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned quotient/remainder.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): RUN still occurs for DIV_LATENCY cycles, and HI/LO are unchanged at commit (pending = current HI/LO).
- `mduOutput` reflects current HI/LO in any state. MF during RUN returns pre-operation values; the pipeline must stall.
- Reset (any time, including mid-RUN): state IDLE, `count`=0, HI=LO=0, pending=0, `mduBusy`=0. In-flight result discarded.

## Timing
- MULT issued at edge t: `mduBusy` high from t through t+MULT_LATENCY−1 edges, i.e. exactly MULT_LATENCY cycles. HI/LO are new and `mduBusy`=0 in the cycle after edge t+MULT_LATENCY.
- DIV follows the same timing with DIV_LATENCY.
- Back-to-back: a new start is accepted the first cycle `mduBusy`=0 (zero bubble).
- MTHI/MTLO: 1-edge write; MFHI/MFLO in the next cycle sees the new value. No forwarding in the same cycle.
- `mduOutput` has zero latency from `mduOperation`. HI/LO change only on edges.

## Structure
- Shared header/package holds the op codes:
  - mduOfNone 4'b0000, mduOfMult 0001, mduOfMultu 0010, mduOfDiv 0011, mduOfDivu 0100.
  - mduOfMfhi 0101, mduOfMflo 0110, mduOfMthi 0111, mduOfMtlo 1000.
  - State encodings IDLE/RUN are also in the package.
- No sub-module. Product/quotient are combinational at issue, and the counter models latency.

## Test plan
- Reset mid-RUN: issue MULT 7×6, assert `reset` after 2 cycles → `mduBusy`=0, HI=LO=0 immediately; MFLO reads 0.
- MULT 0xFFFFFFFF × 2 → `mduBusy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV −7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 after MTHI 0x11 and MTLO 0x22 → 10 busy cycles, then HI=0x11, LO=0x22.
- MTLO 0xAA issued during DIV RUN → ignored; LO = quotient at commit.
- Back-to-back MULT: second MULT issued the first cycle `mduBusy` drops → accepted; MFHI during its RUN returns the first product's HI.
